// File: rtl/ser_pkg.sv
// ser_pkg: shared state encoding, default width and counter sizing for the PISO serializer.
package ser_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
   localparam int DEF_WIDTH = 8;
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: loadable shift register exposing the first bit of a word and the bit after the current head.
module piso_shift_reg
   import ser_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_first,
   output logic             o_next
);
   logic [WIDTH-1:0] r_sr;
   assign o_first = MSB_FIRST ? i_data[WIDTH-1] : i_data[0];
   assign o_next  = MSB_FIRST ? r_sr[WIDTH-2] : r_sr[1];
   always_ff @(posedge clk or posedge reset)
      if (reset) r_sr <= '0;
      else if (i_load) r_sr <= i_data;
      else if (i_shift) r_sr <= MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in serial-out transmitter with framing strobes.
// Define PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
   import ser_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic             o_sd,
   output logic             o_sd_en,
   output logic             o_last,
   output logic             o_done
);
   localparam int CW = cnt_w(WIDTH);
   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_sd, r_en, r_last, r_done;
   logic            w_load, w_first, w_next;
`ifdef PARITY_EN
   logic            r_par;
`endif
   assign o_ready = r_state == IDLE;
   assign w_load  = i_valid && o_ready;
   assign o_sd    = r_sd;
   assign o_sd_en = r_en;
   assign o_last  = r_last;
   assign o_done  = r_done;
   piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sr (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_shift(r_state == SHIFT),
      .i_data (i_data),
      .o_first(w_first),
      .o_next (w_next)
   );
   // r_cnt indexes the bit currently on o_sd; o_sd is loaded one edge ahead of each bit time
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_sd    <= IDLE_LEVEL;
         r_en    <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
`ifdef PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               r_last <= 1'b0;
               r_cnt  <= '0;
               r_sd   <= w_load ? w_first : IDLE_LEVEL;
               r_en   <= w_load;
               if (w_load) r_state <= SHIFT;
`ifdef PARITY_EN
               if (w_load) r_par <= ^i_data;
`endif
            end
            SHIFT:
               if (r_cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
                  r_state <= PAR;
                  r_sd    <= r_par;
                  r_last  <= 1'b1;
`else
                  r_state <= IDLE;
                  r_sd    <= IDLE_LEVEL;
                  r_en    <= 1'b0;
                  r_last  <= 1'b0;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_cnt  <= r_cnt + CW'(1);
                  r_sd   <= w_next;
`ifdef PARITY_EN
                  r_last <= 1'b0;
`else
                  r_last <= r_cnt == CW'(WIDTH - 2);
`endif
               end
`ifdef PARITY_EN
            PAR: begin
               r_state <= IDLE;
               r_sd    <= IDLE_LEVEL;
               r_en    <= 1'b0;
               r_last  <= 1'b0;
               r_done  <= 1'b1;
            end
`endif
            default: begin
               r_state <= IDLE;
               r_sd    <= IDLE_LEVEL;
               r_en    <= 1'b0;
               r_last  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed table-driven bench for piso_serializer (WIDTH=8), MSB- and LSB-first instances.
module tb_piso_serializer;
`ifdef PARITY_EN
   localparam int F = 9;
`else
   localparam int F = 8;
`endif
   typedef struct {
      logic [7:0] d;
      logic [7:0] s_msb;
      logic [7:0] s_lsb;
      logic       par;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] a_data = '0, b_data = '0;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       a_ready, a_sd, a_en, a_last, a_done;
   logic       b_ready, b_sd, b_en, b_last, b_done;
   int         checks = 0, failures = 0;
   vec_t       tbl[4];
   always #5 clk = ~clk;
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
      .clk(clk), .reset(reset), .i_data(a_data), .i_valid(a_valid), .o_ready(a_ready),
      .o_sd(a_sd), .o_sd_en(a_en), .o_last(a_last), .o_done(a_done));
   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
      .clk(clk), .reset(reset), .i_data(b_data), .i_valid(b_valid), .o_ready(b_ready),
      .o_sd(b_sd), .o_sd_en(b_en), .o_last(b_last), .o_done(b_done));
   task automatic chk(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", n, a, e);
      end
   endtask
   function automatic logic eb(input logic [7:0] s, input logic p, input int k);
      return (k > 8) ? p : s[8-k];
   endfunction
   task automatic chk_a(input string t, input logic sd, input logic en, input logic last, input logic done, input logic rdy);
      chk({t, " a_sd"}, a_sd, sd);
      chk({t, " a_en"}, a_en, en);
      chk({t, " a_last"}, a_last, last);
      chk({t, " a_done"}, a_done, done);
      chk({t, " a_ready"}, a_ready, rdy);
   endtask
   task automatic chk_b(input string t, input logic sd, input logic en, input logic last, input logic done, input logic rdy);
      chk({t, " b_sd"}, b_sd, sd);
      chk({t, " b_en"}, b_en, en);
      chk({t, " b_last"}, b_last, last);
      chk({t, " b_done"}, b_done, done);
      chk({t, " b_ready"}, b_ready, rdy);
   endtask
   task automatic run_frame(input vec_t v);
      string t;
      @(negedge clk);
      a_valid = 1'b1; a_data = v.d;
      b_valid = 1'b1; b_data = v.d;
      for (int k = 1; k <= F; k++) begin
         @(negedge clk);
         if (k == 1) begin
            a_valid = 1'b0; a_data = ~v.d;
            b_valid = 1'b0; b_data = ~v.d;
         end
         t = $sformatf("frm %h c%0d", v.d, k);
         chk_a(t, eb(v.s_msb, v.par, k), 1'b1, k == F, 1'b0, 1'b0);
         chk_b(t, eb(v.s_lsb, v.par, k), 1'b1, k == F, 1'b0, 1'b0);
      end
      @(negedge clk);
      t = $sformatf("frm %h done", v.d);
      chk_a(t, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk_b(t, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      t = $sformatf("frm %h post", v.d);
      chk_a(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_b(t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      tbl[0] = '{d: 8'hC4, s_msb: 8'b1100_0100, s_lsb: 8'b0010_0011, par: 1'b1};
      tbl[1] = '{d: 8'h0F, s_msb: 8'b0000_1111, s_lsb: 8'b1111_0000, par: 1'b0};
      tbl[2] = '{d: 8'hA5, s_msb: 8'b1010_0101, s_lsb: 8'b1010_0101, par: 1'b0};
      tbl[3] = '{d: 8'h01, s_msb: 8'b0000_0001, s_lsb: 8'b1000_0000, par: 1'b1};
      repeat (2) @(negedge clk);
      chk_a("in reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk_a($sformatf("idle c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         chk_b($sformatf("idle c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      for (int i = 0; i < 4; i++) run_frame(tbl[i]);
      // back-to-back with i_valid held: C4 then 0F, one gap cycle carrying o_done
      @(negedge clk);
      a_valid = 1'b1; a_data = 8'hC4;
      for (int k = 1; k <= F; k++) begin
         @(negedge clk);
         if (k == 1) a_data = 8'h0F;
         chk_a($sformatf("b2b1 c%0d", k), eb(8'hC4, 1'b1, k), 1'b1, k == F, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk_a("b2b gap", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= F; k++) begin
         @(negedge clk);
         if (k == 1) begin a_valid = 1'b0; a_data = 8'h55; end
         chk_a($sformatf("b2b2 c%0d", k), eb(8'h0F, 1'b0, k), 1'b1, k == F, 1'b0, 1'b0);
      end
      @(negedge clk);
      chk_a("b2b2 done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk_a("b2b2 post", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      // reset on cycle 4 of an FF frame
      a_valid = 1'b1; a_data = 8'hFF;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         a_valid = 1'b0;
         chk_a($sformatf("ff c%0d", k), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      reset = 1'b1;
      #1;
      chk_a("abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk_a($sformatf("after abort c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      run_frame(tbl[0]);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
